// File: rtl/bfly10_stage.sv
// Radix-2 butterfly stage: buffers the first half of each frame and combines it
// beat-by-beat with the second half, producing registered sum/diff per lane.
module bfly10_stage #(
  parameter int IN_WIDTH = 11,
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_valid,
  input  logic [IN_WIDTH-1:0] i_re [0:15],
  input  logic [IN_WIDTH-1:0] i_im [0:15],
  output logic                o_bfly10_valid,
  output logic [WIDTH-1:0]    o_bfly10_sum_re  [0:15],
  output logic [WIDTH-1:0]    o_bfly10_sum_im  [0:15],
  output logic [WIDTH-1:0]    o_bfly10_diff_re [0:15],
  output logic [WIDTH-1:0]    o_bfly10_diff_im [0:15]
);

  localparam int LANES = 16;
  localparam int CNT_W = $clog2(2 * DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(2 * DEPTH - 1);

  logic [CNT_W-1:0]    beat_cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                fill_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [IDX_W-1:0]    rd_idx_s;

  logic [IN_WIDTH-1:0] mem_re_r [0:DEPTH-1][0:LANES-1];
  logic [IN_WIDTH-1:0] mem_im_r [0:DEPTH-1][0:LANES-1];

  logic [WIDTH-1:0]    sum_re_s  [0:LANES-1];
  logic [WIDTH-1:0]    sum_im_s  [0:LANES-1];
  logic [WIDTH-1:0]    diff_re_s [0:LANES-1];
  logic [WIDTH-1:0]    diff_im_s [0:LANES-1];

  function automatic logic [WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] x);
    sext = {{(WIDTH - IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  // Beat counter next value, buffer indices and full-precision butterfly arithmetic
  always_comb begin
    fill_s   = (beat_cnt_r < DEPTH_C);
    wr_idx_s = IDX_W'(beat_cnt_r);
    rd_idx_s = IDX_W'(beat_cnt_r - DEPTH_C);
    if (beat_cnt_r == LAST_C) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = beat_cnt_r + CNT_W'(1);
    end
    for (int j = 0; j < LANES; j++) begin
      sum_re_s[j]  = sext(mem_re_r[rd_idx_s][j]) + sext(i_re[j]);
      sum_im_s[j]  = sext(mem_im_r[rd_idx_s][j]) + sext(i_im[j]);
      diff_re_s[j] = sext(mem_re_r[rd_idx_s][j]) - sext(i_re[j]);
      diff_im_s[j] = sext(mem_im_r[rd_idx_s][j]) - sext(i_im[j]);
    end
  end

  // First-half buffer; writes only occur in FILL, so a CALC read is never disturbed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int j = 0; j < LANES; j++) begin
          mem_re_r[d][j] <= '0;
          mem_im_r[d][j] <= '0;
        end
      end
    end else if (i_valid && fill_s) begin
      for (int j = 0; j < LANES; j++) begin
        mem_re_r[wr_idx_s][j] <= i_re[j];
        mem_im_r[wr_idx_s][j] <= i_im[j];
      end
    end
  end

  // Beat counting and registered outputs; results hold across bubbles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_r     <= '0;
      o_bfly10_valid <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        o_bfly10_sum_re[j]  <= '0;
        o_bfly10_sum_im[j]  <= '0;
        o_bfly10_diff_re[j] <= '0;
        o_bfly10_diff_im[j] <= '0;
      end
    end else begin
      o_bfly10_valid <= 1'b0;
      if (i_valid) begin
        beat_cnt_r <= cnt_nxt_s;
        if (!fill_s) begin
          o_bfly10_valid <= 1'b1;
          for (int j = 0; j < LANES; j++) begin
            o_bfly10_sum_re[j]  <= sum_re_s[j];
            o_bfly10_sum_im[j]  <= sum_im_s[j];
            o_bfly10_diff_re[j] <= diff_re_s[j];
            o_bfly10_diff_im[j] <= diff_im_s[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bfly10_stage.sv
// Directed bench for bfly10_stage: reset, ramp, extremes, bubbles,
// back-to-back frames and mid-frame reset, checked with immediate assertions.
module tb_bfly10_stage;
  localparam int L = 16;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic [10:0] i_re [0:L-1];
  logic [10:0] i_im [0:L-1];
  logic        o_bfly10_valid;
  logic [11:0] sum_re  [0:L-1];
  logic [11:0] sum_im  [0:L-1];
  logic [11:0] diff_re [0:L-1];
  logic [11:0] diff_im [0:L-1];

  logic signed [10:0] fr_re [0:7][0:L-1];
  logic signed [10:0] fr_im [0:7][0:L-1];
  logic [11:0] e_sr [0:L-1];
  logic [11:0] e_si [0:L-1];
  logic [11:0] e_dr [0:L-1];
  logic [11:0] e_di [0:L-1];

  int vec = 0;
  int mis = 0;
  int vcount;

  bfly10_stage dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_valid          (i_valid),
    .i_re             (i_re),
    .i_im             (i_im),
    .o_bfly10_valid   (o_bfly10_valid),
    .o_bfly10_sum_re  (sum_re),
    .o_bfly10_sum_im  (sum_im),
    .o_bfly10_diff_re (diff_re),
    .o_bfly10_diff_im (diff_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_valid(input string tag, input logic exp);
    vec++;
    assert (o_bfly10_valid === exp) else begin
      mis++;
      $error("FAIL %s_valid: observed %b expected %b", tag, o_bfly10_valid, exp);
    end
  endtask

  task automatic chk_lanes(input string tag);
    for (int j = 0; j < L; j++) begin
      chk($sformatf("%s_sum_re[%0d]", tag, j), sum_re[j], e_sr[j]);
      chk($sformatf("%s_sum_im[%0d]", tag, j), sum_im[j], e_si[j]);
      chk($sformatf("%s_diff_re[%0d]", tag, j), diff_re[j], e_dr[j]);
      chk($sformatf("%s_diff_im[%0d]", tag, j), diff_im[j], e_di[j]);
    end
  endtask

  task automatic clear_exp();
    for (int j = 0; j < L; j++) begin
      e_sr[j] = 12'd0; e_si[j] = 12'd0; e_dr[j] = 12'd0; e_di[j] = 12'd0;
    end
  endtask

  task automatic drive(input int b);
    i_valid = 1'b1;
    for (int j = 0; j < L; j++) begin
      i_re[j] = fr_re[b][j];
      i_im[j] = fr_im[b][j];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    i_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      chk_valid(tag, 1'b0);
      chk_lanes(tag);
    end
  endtask

  task automatic fill_ramp();
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < L; j++) begin
        fr_re[b][j] = 11'(b * 16 + j);
        fr_im[b][j] = 11'(-(b * 16 + j));
      end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < L; j++) begin
        fr_re[b][j] = 11'($urandom);
        fr_im[b][j] = 11'($urandom);
      end
  endtask

  // Closed-form result of the ramp frame for output beat k
  task automatic ramp_beat(input string tag, input int b);
    drive(b);
    if (b >= 4) begin
      for (int j = 0; j < L; j++) begin
        e_sr[j] = 12'((2 * (b - 4) + 4) * 16 + 2 * j);
        e_si[j] = 12'(-((2 * (b - 4) + 4) * 16 + 2 * j));
        e_dr[j] = 12'(-64);
        e_di[j] = 12'(64);
      end
    end
    chk_valid(tag, (b >= 4) ? 1'b1 : 1'b0);
    chk_lanes(tag);
  endtask

  task automatic model_beat(input string tag, input int b);
    logic signed [11:0] a, c;
    drive(b);
    if (b >= 4) begin
      for (int j = 0; j < L; j++) begin
        a = fr_re[b-4][j]; c = fr_re[b][j];
        e_sr[j] = a + c; e_dr[j] = a - c;
        a = fr_im[b-4][j]; c = fr_im[b][j];
        e_si[j] = a + c; e_di[j] = a - c;
      end
    end
    if (o_bfly10_valid) vcount++;
    chk_valid(tag, (b >= 4) ? 1'b1 : 1'b0);
    chk_lanes(tag);
  endtask

  initial begin
    rstn = 1'b0;
    i_valid = 1'b1;
    for (int j = 0; j < L; j++) begin
      i_re[j] = 11'($urandom);
      i_im[j] = 11'($urandom);
    end
    clear_exp();

    // 1: reset held with i_valid high
    repeat (3) @(posedge clk);
    #1;
    chk_valid("reset", 1'b0);
    chk_lanes("reset");
    rstn = 1'b1;

    // 2: ramp frame, first beat after release is beat 0
    fill_ramp();
    for (int b = 0; b < 8; b++) ramp_beat("ramp", b);
    idle("ramp_idle", 2);

    // 3: extremes
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < L; j++) begin
        fr_re[b][j] = 11'sd0;
        fr_im[b][j] = 11'sd0;
      end
    for (int j = 0; j < L; j++) begin
      fr_re[0][j] = -11'sd1024; fr_im[0][j] = 11'sd1023;
      fr_re[1][j] = 11'sd1023;  fr_im[1][j] = -11'sd1024;
      fr_re[4][j] = -11'sd1024; fr_im[4][j] = 11'sd1023;
      fr_re[5][j] = -11'sd1024; fr_im[5][j] = 11'sd1023;
    end
    for (int b = 0; b < 4; b++) begin
      drive(b);
      chk_valid("ext_fill", 1'b0);
      chk_lanes("ext_fill");
    end
    drive(4);
    for (int j = 0; j < L; j++) begin
      e_sr[j] = 12'(-2048); e_dr[j] = 12'd0; e_si[j] = 12'd2046; e_di[j] = 12'd0;
    end
    chk_valid("ext4", 1'b1);
    chk_lanes("ext4");
    drive(5);
    for (int j = 0; j < L; j++) begin
      e_sr[j] = 12'(-1); e_dr[j] = 12'd2047; e_si[j] = 12'(-1); e_di[j] = 12'(-2047);
    end
    chk_valid("ext5", 1'b1);
    chk_lanes("ext5");
    drive(6);
    clear_exp();
    chk_valid("ext6", 1'b1);
    chk_lanes("ext6");
    drive(7);
    chk_valid("ext7", 1'b1);
    chk_lanes("ext7");

    // 4: bubbles after beats 2 and 5
    fill_ramp();
    for (int b = 0; b < 3; b++) ramp_beat("bub", b);
    idle("bub_gap1", 1);
    for (int b = 3; b < 6; b++) ramp_beat("bub", b);
    idle("bub_gap3", 3);
    for (int b = 6; b < 8; b++) ramp_beat("bub", b);

    // 5: three back-to-back random frames
    vcount = 0;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      for (int b = 0; b < 8; b++) model_beat("b2b", b);
    end
    i_valid = 1'b0;
    chk("b2b_valid_count", 12'(vcount), 12'd12);

    // 6: reset after beat 5, then a fresh frame
    fill_rand();
    for (int b = 0; b < 6; b++) model_beat("pre_rst", b);
    i_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    clear_exp();
    chk_valid("mid_rst", 1'b0);
    chk_lanes("mid_rst");
    @(posedge clk);
    #1 rstn = 1'b1;
    fill_rand();
    for (int b = 0; b < 8; b++) model_beat("post_rst", b);
    i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
